// File: rtl/jt6295_cmd_tx.sv
// ---------------------------------------------------------------------------
// jt6295_cmd_tx
//
// CPU-side command transmitter for the JT6295 ADPCM core. High-level play and
// stop requests are queued through a valid/ready FIFO. Each request is then
// serialised onto the chip's byte-wide write port (wrn/dout), with all
// protocol timing paced by the cen clock enable. After the second byte of a
// play command the block waits for the target channels to report busy. This
// keeps a following start command from reaching a channel before the chip has
// latched the previous one.
//
// Parameters
//   DEPTH    request FIFO depth (power of two, >= 2)
//   WR_LOW   cen ticks with wrn low per byte (>= 1)
//   HOLD     cen ticks dout is held after wrn rises (>= 1)
//   GAP      idle cen ticks between the two bytes of a play command (>= 1)
//   TIMEOUT  cen ticks to wait for busy before flagging to_err (>= 1)
//
// Ports
//   rst        in   synchronous reset, active-high
//   clk        in   system clock
//   cen        in   protocol pacing enable
//   req_valid  in   request present
//   req_ready  out  queue can accept (not full)
//   req_stop   in   1 = stop request, 0 = play request
//   req_phrase in   phrase number (play only)
//   req_ch     in   channel mask
//   req_att    in   attenuation code (play only)
//   busy       in   channel busy flags from the chip
//   clr_err    in   clears to_err
//   wrn        out  write strobe, active-low, data taken on its rising edge
//   dout       out  write data to the chip
//   sent       out  one-clk pulse when a request has fully completed
//   idle       out  FIFO empty and FSM idle
//   to_err     out  sticky busy-wait timeout flag
// ---------------------------------------------------------------------------
module jt6295_cmd_tx #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned WR_LOW  = 2,
  parameter int unsigned HOLD    = 1,
  parameter int unsigned GAP     = 2,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic       rst,
  input  logic       clk,
  input  logic       cen,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_stop,
  input  logic [6:0] req_phrase,
  input  logic [3:0] req_ch,
  input  logic [3:0] req_att,
  input  logic [3:0] busy,
  input  logic       clr_err,
  output logic       wrn,
  output logic [7:0] dout,
  output logic       sent,
  output logic       idle,
  output logic       to_err
);

  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OW   = AW + 1;
  localparam int unsigned MAX1 = (WR_LOW > HOLD) ? WR_LOW : HOLD;
  localparam int unsigned MAX2 = (MAX1 > GAP) ? MAX1 : GAP;
  localparam int unsigned MAXC = (MAX2 > TIMEOUT) ? MAX2 : TIMEOUT;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  typedef struct packed {
    logic       stop;
    logic [6:0] phrase;
    logic [3:0] ch;
    logic [3:0] att;
  } entry_t;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StLow,
    StRise,
    StGap,
    StWaitb,
    StDone
  } state_e;

  // -------------------------------------------------------------------------
  // Request FIFO
  // -------------------------------------------------------------------------
  entry_t        r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [OW-1:0] r_count;

  logic   w_full;
  logic   w_empty;
  logic   w_push;
  logic   w_pop;
  entry_t w_in;
  entry_t w_head;

  assign w_full    = (r_count == OW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign req_ready = ~w_full;
  assign w_push    = req_valid & ~w_full;
  assign w_in      = '{stop: req_stop, phrase: req_phrase, ch: req_ch, att: req_att};
  assign w_head    = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_in;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      // Simultaneous push and pop leaves occupancy unchanged.
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Write-protocol FSM
  // -------------------------------------------------------------------------
  state_e        r_state;
  state_e        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  entry_t        r_cmd;
  entry_t        w_cmd_nxt;
  logic          r_byte2;
  logic          w_byte2_nxt;
  logic [7:0]    r_dout;
  logic [7:0]    w_dout_nxt;
  logic          r_err;
  logic          w_set_err;
  logic [7:0]    w_byte1;
  logic          w_busy_ok;

  // First byte of whatever request sits at the FIFO head.
  assign w_byte1 = w_head.stop ? {1'b0, w_head.ch, 3'b000} : {1'b1, w_head.phrase};

  // An empty mask is trivially satisfied, so ch == 0 leaves WAITB at once.
  assign w_busy_ok = ((busy & r_cmd.ch) == r_cmd.ch);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cmd_nxt   = r_cmd;
    w_byte2_nxt = r_byte2;
    w_dout_nxt  = r_dout;
    w_pop       = 1'b0;
    w_set_err   = 1'b0;

    case (r_state)
      StIdle: begin
        // Not gated by cen: a queued request is picked up on any clk.
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_cmd_nxt   = w_head;
          w_byte2_nxt = 1'b0;
          w_dout_nxt  = w_byte1;
          w_cnt_nxt   = '0;
          w_state_nxt = StSetup;
        end
      end

      StSetup: begin
        if (cen) begin
          w_cnt_nxt   = '0;
          w_state_nxt = StLow;
        end
      end

      StLow: begin
        if (cen) begin
          if (r_cnt == CW'(WR_LOW - 1)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = StRise;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end

      StRise: begin
        if (cen) begin
          if (r_cnt == CW'(HOLD - 1)) begin
            w_cnt_nxt = '0;
            if (r_cmd.stop) begin
              w_state_nxt = StDone;
            end else if (!r_byte2) begin
              w_state_nxt = StGap;
            end else begin
              w_state_nxt = StWaitb;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end

      StGap: begin
        if (cen) begin
          if (r_cnt == CW'(GAP - 1)) begin
            w_cnt_nxt   = '0;
            w_byte2_nxt = 1'b1;
            w_dout_nxt  = {r_cmd.ch, r_cmd.att};
            w_state_nxt = StSetup;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end

      StWaitb: begin
        // busy is sampled every clk; only the timeout counts cen ticks.
        if (w_busy_ok) begin
          w_cnt_nxt   = '0;
          w_state_nxt = StDone;
        end else if (cen) begin
          if (r_cnt == CW'(TIMEOUT - 1)) begin
            w_cnt_nxt   = '0;
            w_set_err   = 1'b1;
            w_state_nxt = StDone;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end

      StDone: begin
        // Leaves on the next clk regardless of cen so sent is one clk wide.
        w_state_nxt = StIdle;
      end

      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_cmd   <= '0;
      r_byte2 <= 1'b0;
      r_dout  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cmd   <= w_cmd_nxt;
      r_byte2 <= w_byte2_nxt;
      r_dout  <= w_dout_nxt;
    end
  end

  // A timeout in the same clk as clr_err keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_set_err) begin
      r_err <= 1'b1;
    end else if (clr_err) begin
      r_err <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // rst forces wrn high within the reset cycle itself; the chip shares rst,
  // so that rising edge is not taken as a write.
  assign wrn    = (r_state != StLow) | rst;
  assign dout   = r_dout;
  assign sent   = (r_state == StDone);
  assign idle   = w_empty & (r_state == StIdle);
  assign to_err = r_err;

endmodule

// File: tb/tb_jt6295_cmd_tx.sv
// ---------------------------------------------------------------------------
// tb_jt6295_cmd_tx
//
// Self-checking bench for jt6295_cmd_tx. Accepted requests are expanded into
// the bytes the chip should see and the clk at which each request should
// complete. These values are derived from the protocol rules in units of the
// cen period. A per-clk monitor compares wrn/dout/sent/to_err against that
// model.
// ---------------------------------------------------------------------------
module tb_jt6295_cmd_tx;

  localparam int DEPTH   = 4;
  localparam int WR_LOW  = 2;
  localparam int HOLD    = 1;
  localparam int GAP     = 2;
  localparam int TIMEOUT = 16;

  logic       rst;
  logic       clk;
  logic       cen;
  logic       req_valid;
  logic       req_ready;
  logic       req_stop;
  logic [6:0] req_phrase;
  logic [3:0] req_ch;
  logic [3:0] req_att;
  logic [3:0] busy;
  logic       clr_err;
  logic       wrn;
  logic [7:0] dout;
  logic       sent;
  logic       idle;
  logic       to_err;

  jt6295_cmd_tx #(
    .DEPTH  (DEPTH),
    .WR_LOW (WR_LOW),
    .HOLD   (HOLD),
    .GAP    (GAP),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .rst       (rst),
    .clk       (clk),
    .cen       (cen),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_stop  (req_stop),
    .req_phrase(req_phrase),
    .req_ch    (req_ch),
    .req_att   (req_att),
    .busy      (busy),
    .clr_err   (clr_err),
    .wrn       (wrn),
    .dout      (dout),
    .sent      (sent),
    .idle      (idle),
    .to_err    (to_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 0 stop byte, 1 play byte 1, 2 play byte 2
  typedef struct {
    logic [7:0] b;
    int         kind;
    logic [3:0] ch;
  } xbyte_t;

  typedef struct {
    int t;
    bit err;
  } xsent_t;

  xbyte_t     exp_b[$];
  xsent_t     exp_s[$];

  int         n_chk;
  int         n_pass;
  int         cyc;
  int         cen_per;
  int         busy_at;
  logic [3:0] busy_val;
  int         busy_mode;   // 0 random, 1 fixed delay, 2 never
  int         busy_delay;
  logic       prev_wrn;
  logic [7:0] cur_b;
  logic [7:0] last_b;
  int         fall_t;
  int         rise1_t;
  bit         stable;
  bit         model_err;
  bit         last_acc;

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, act, exp, cyc);
  endtask

  task automatic push_sent(input int t, input bit err);
    xsent_t s;
    s.t   = t;
    s.err = err;
    exp_s.push_back(s);
  endtask

  // Expand one accepted request into the chip-visible byte sequence.
  task automatic model_accept(input bit s, input logic [6:0] p, input logic [3:0] c,
                              input logic [3:0] a);
    xbyte_t e;
    e.ch = c;
    if (s) begin
      e.b = {1'b0, c, 3'b000}; e.kind = 0; exp_b.push_back(e);
    end else begin
      e.b = {1'b1, p}; e.kind = 1; exp_b.push_back(e);
      e.b = {c, a};    e.kind = 2; exp_b.push_back(e);
    end
  endtask

  task automatic model_reset();
    exp_b.delete();
    exp_s.delete();
    model_err = 1'b0;
    busy      = '0;
    busy_at   = -1;
    prev_wrn  = wrn;
  endtask

  // Busy wait after play byte 2 rose at clk r: completion is the later of
  // WAITB entry and busy arrival, plus one clk, capped by the timeout.
  task automatic schedule_busy(input int r, input logic [3:0] ch);
    int  w;
    int  lim;
    int  b;
    int  ts;
    bit  never;
    w     = r + HOLD * cen_per;
    lim   = w + TIMEOUT * cen_per;
    never = (busy_mode == 2) || (busy_mode == 0 && $urandom_range(3) == 0);
    if (ch == 4'h0) begin
      push_sent(w + 1, 1'b0);
    end else begin
      if (busy_mode == 1) b = r + busy_delay;
      else b = r + int'($urandom_range(HOLD * cen_per + TIMEOUT * cen_per + 2));
      ts = ((b > w) ? b : w) + 1;
      if (never || ts > lim) push_sent(lim, 1'b1);
      else push_sent(ts, 1'b0);
      if (!never) begin
        busy_at  = b;
        busy_val = ch | 4'($urandom);
      end
    end
  endtask

  task automatic monitor(input bit clr_now);
    bit     set_now;
    xbyte_t e;
    xsent_t s;
    set_now = 1'b0;
    if (prev_wrn && !wrn) begin
      cur_b  = dout;
      fall_t = cyc;
      stable = 1'b1;
      if (exp_b.size() == 0) check("spurious_wr", int'(wrn), 1);
      else if (exp_b[0].kind == 2) check("gap", cyc - rise1_t, (HOLD + GAP + 1) * cen_per);
    end else if (!prev_wrn && !wrn) begin
      if (dout != cur_b) stable = 1'b0;
    end else if (!prev_wrn && wrn) begin
      check("hold", int'(dout), int'(cur_b));
      check("low_w", cyc - fall_t, WR_LOW * cen_per);
      check("stable", int'(stable), 1);
      last_b = cur_b;
      if (exp_b.size() != 0) begin
        e = exp_b.pop_front();
        check("byte", int'(cur_b), int'(e.b));
        case (e.kind)
          0:       push_sent(cyc + HOLD * cen_per, 1'b0);
          1:       rise1_t = cyc;
          default: schedule_busy(cyc, e.ch);
        endcase
      end
    end
    prev_wrn = wrn;

    if (exp_s.size() != 0 && exp_s[0].t == cyc) begin
      s = exp_s.pop_front();
      check("sent", int'(sent), 1);
      set_now = s.err;
      busy    = '0;
      busy_at = -1;
    end else if (sent) begin
      check("sent_extra", int'(sent), 0);
    end
    if (set_now) model_err = 1'b1;
    else if (clr_now) model_err = 1'b0;
    check("to_err", int'(to_err), int'(model_err));
  endtask

  // One clk: inputs were driven after the previous sample; sample at negedge.
  task automatic tick();
    bit acc;
    bit clr_now;
    bit rst_now;
    acc     = req_valid && req_ready && !rst;
    clr_now = clr_err;
    rst_now = rst;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    last_acc = acc;
    if (rst_now) model_reset();
    else begin
      if (acc) model_accept(req_stop, req_phrase, req_ch, req_att);
      monitor(clr_now);
    end
    cen = (((cyc + 1) % cen_per) == 0);
    if (busy_at == cyc) busy = busy_val;
  endtask

  task automatic push_req(input bit s, input logic [6:0] p, input logic [3:0] c,
                          input logic [3:0] a);
    int n;
    n          = 0;
    req_stop   = s;
    req_phrase = p;
    req_ch     = c;
    req_att    = a;
    req_valid  = 1'b1;
    last_acc   = 1'b0;
    while (!last_acc && n < 500) begin
      tick();
      n++;
    end
    req_valid = 1'b0;
    if (!last_acc) check("push_timeout", int'(req_ready), 1);
  endtask

  task automatic push_rand();
    push_req($urandom_range(3) == 0, 7'($urandom), 4'($urandom), 4'($urandom));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (!(idle && exp_b.size() == 0 && exp_s.size() == 0) && n < 3000) begin
      tick();
      n++;
    end
    check("drain_pending", exp_b.size() + exp_s.size(), 0);
    check("idle", int'(idle), 1);
  endtask

  task automatic wait_low();
    int n;
    n = 0;
    while (wrn && n < 200) begin
      tick();
      n++;
    end
    check("wait_low", int'(wrn), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0; cen_per = 1;
    busy_at = -1; busy_val = '0; busy_mode = 0; busy_delay = 0;
    prev_wrn = 1'b1; cur_b = '0; last_b = '0; fall_t = 0; rise1_t = 0;
    stable = 1'b1; model_err = 1'b0; last_acc = 1'b0;
    rst = 1'b1; cen = 1'b1; req_valid = 1'b0; req_stop = 1'b0; req_phrase = '0;
    req_ch = '0; req_att = '0; busy = '0; clr_err = 1'b0;

    repeat (3) tick();
    rst = 1'b0;
    check("rst_wrn", int'(wrn), 1);
    check("rst_dout", int'(dout), 0);
    check("rst_sent", int'(sent), 0);
    check("rst_idle", int'(idle), 1);
    check("rst_ready", int'(req_ready), 1);
    check("rst_to_err", int'(to_err), 0);

    // Stop on channels 0 and 2.
    push_req(1'b1, 7'h00, 4'b0101, 4'h0);
    wait_drain();
    check("stop_byte", int'(last_b), 'h28);

    // Play answered by busy three cen ticks after byte 2.
    busy_mode = 1; busy_delay = 3 * cen_per;
    push_req(1'b0, 7'h15, 4'b0010, 4'h3);
    wait_drain();
    check("play_byte2", int'(last_b), 'h23);
    check("play_no_err", int'(to_err), 0);

    // Same play with busy never arriving: timeout, then clear.
    busy_mode = 2;
    push_req(1'b0, 7'h15, 4'b0010, 4'h3);
    wait_drain();
    check("timeout_err", int'(to_err), 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("clr_err", int'(to_err), 0);

    // Back-to-back pushes while a play is in flight fill the FIFO.
    push_req(1'b0, 7'h2a, 4'b1000, 4'h1);
    wait_low();
    for (int k = 0; k < 5; k++) begin
      push_req(1'b1, 7'h00, 4'($urandom), 4'h0);
      check("b2b_ready", int'(req_ready), (k < DEPTH - 1) ? 1 : 0);
    end
    wait_drain();

    // Slow cen: every phase stretches by the cen period.
    busy_mode = 0; cen_per = 4;
    for (int i = 0; i < 5; i++) push_rand();
    wait_drain();

    // Randomised traffic across cen rates with occasional clr_err pulses.
    for (int i = 0; i < 40; i++) begin
      if (i % 10 == 0) begin
        wait_drain();
        cen_per = (i == 10) ? 2 : (i == 20) ? 4 : 1;
      end
      push_rand();
      repeat ($urandom_range(6)) begin
        clr_err = ($urandom_range(15) == 0);
        tick();
      end
      clr_err = 1'b0;
    end
    wait_drain();

    // Reset while wrn is low with another request queued.
    cen_per = 1; busy_mode = 2;
    push_req(1'b0, 7'h33, 4'b0100, 4'h7);
    push_req(1'b1, 7'h00, 4'b0001, 4'h0);
    wait_low();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_wrn", int'(wrn), 1);
    check("mid_rst_dout", int'(dout), 0);
    check("mid_rst_idle", int'(idle), 1);
    check("mid_rst_ready", int'(req_ready), 1);
    check("mid_rst_sent", int'(sent), 0);
    repeat (30) tick();
    check("post_rst_idle", int'(idle), 1);
    check("post_rst_wrn", int'(wrn), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
